// File: rtl/rs_uart_pkg.sv
// Shared definitions for the RS <-> UART bridge FSMs (Tx and Rx side).
package rs_uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

  // Frame marker sent ahead of each codeword when framing sync is built in.
  localparam logic [7:0] SYNC_BYTE = 8'h47;

  // Data bytes per RS codeword frame; shared with the Rx-side FSM.
  localparam int FRAME_LEN_DEF = 204;

endpackage

// File: rtl/rs_tx_fifo.sv
// Synchronous first-word-fall-through FIFO: dout always shows the head entry,
// which becomes visible the cycle after it is written. Power-of-2 depth so
// the pointers wrap naturally.
module rs_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_W-1:0]             din,
  output logic [DATA_W-1:0]             dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     count;
  logic              do_push, do_pop;

  // Full/empty come from the registered count, so a pop in the same cycle
  // never makes room for a push that arrives while full.
  assign full    = (count == LW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];
  assign level   = count;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rs_uart_tx_fsm.sv
// RS core -> UART Tx bridge. Buffers non-stallable byte strobes in a FIFO and
// hands them one at a time to the UART using a Tx_WR pulse / Tx_BUSY handshake,
// counting completed data bytes per codeword frame.
// Optional: define RS_UART_TX_SYNC_EN to prefix every frame with SYNC_BYTE.
module rs_uart_tx_fsm
  import rs_uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_LEN  = FRAME_LEN_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             in_byte,
  input  logic                          in_valid,
  output logic [DATA_W-1:0]             Tx_DATA,
  output logic                          Tx_WR,
  input  logic                          Tx_BUSY,
  output logic                          frame_done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  tx_state_e         state, state_nxt;
  logic [7:0]        byte_cnt;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic              load_sync, byte_done, data_done, frame_end;
`ifdef RS_UART_TX_SYNC_EN
  logic              sync_flag;  // sync byte already sent for this frame
  logic              cur_sync;   // byte in flight is the sync byte
`endif

  rs_tx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid),
    .pop   (fifo_pop),
    .din   (in_byte),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode plus the pop / sync-load / byte-complete strobes.
  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    load_sync = 1'b0;
    byte_done = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !Tx_BUSY) begin
`ifdef RS_UART_TX_SYNC_EN
          load_sync = (byte_cnt == '0) && !sync_flag;
`endif
          fifo_pop  = !load_sync;
          state_nxt = SEND;
        end
      end
      SEND:      state_nxt = WAIT_ACK;
      WAIT_ACK:  if (Tx_BUSY) state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (!Tx_BUSY) begin
          byte_done = 1'b1;
          state_nxt = IDLE;
        end
      end
      default:   state_nxt = IDLE;
    endcase
  end

`ifdef RS_UART_TX_SYNC_EN
  assign data_done = byte_done & ~cur_sync;
`else
  assign data_done = byte_done;
`endif
  assign frame_end = data_done && (byte_cnt == 8'(FRAME_LEN - 1));

  // Registered UART-facing outputs, status flags and the frame byte counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      Tx_DATA    <= '0;
      Tx_WR      <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      byte_cnt   <= '0;
    end else begin
      Tx_WR      <= (state_nxt == SEND);
      frame_done <= frame_end;
      if (fifo_pop)       Tx_DATA <= fifo_dout;
      else if (load_sync) Tx_DATA <= DATA_W'(SYNC_BYTE);
      if (in_valid && fifo_full) overflow <= 1'b1;
      if (frame_end)      byte_cnt <= '0;
      else if (data_done) byte_cnt <= byte_cnt + 8'd1;
    end
  end

`ifdef RS_UART_TX_SYNC_EN
  // Sync bookkeeping: one marker per frame, re-armed when the frame closes.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_flag <= 1'b0;
      cur_sync  <= 1'b0;
    end else begin
      if (load_sync)      cur_sync <= 1'b1;
      else if (fifo_pop)  cur_sync <= 1'b0;
      if (load_sync)      sync_flag <= 1'b1;
      else if (frame_end) sync_flag <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_rs_uart_tx_fsm.sv
// Self-checking bench for rs_uart_tx_fsm: UART model with fixed busy time,
// scoreboard of expected Tx bytes, table-driven overflow sequence.
module tb_rs_uart_tx_fsm;
  import rs_uart_pkg::*;

`ifdef RS_UART_TX_SYNC_EN
  localparam bit SYNC = 1'b1;
  localparam int FL   = 2;
`else
  localparam bit SYNC = 1'b0;
  localparam int FL   = 4;
`endif
  localparam int DEPTH    = 16;
  localparam int LW       = 5;
  localparam int BUSY_LEN = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    in_byte = '0;
  logic          in_valid = 1'b0;
  logic [7:0]    Tx_DATA;
  logic          Tx_WR;
  logic          Tx_BUSY;
  logic          frame_done;
  logic          overflow;
  logic [LW-1:0] fifo_level;
  logic          busy = 1'b0;
  logic          hold = 1'b0;

  assign Tx_BUSY = busy | hold;
  always #5 clk = ~clk;

  rs_uart_tx_fsm #(.DATA_W(8), .FIFO_DEPTH(DEPTH), .FRAME_LEN(FL)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .Tx_DATA    (Tx_DATA),
    .Tx_WR      (Tx_WR),
    .Tx_BUSY    (Tx_BUSY),
    .frame_done (frame_done),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  int         n_chk = 0, n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] seen[$];
  int         m_cnt = 0, m_frames = 0, fd_cnt = 0, wr_total = 0, busy_cnt = 0;
  bit         m_sync = 1'b0, fd_prev = 1'b0;

  typedef struct {
    logic [7:0] b;
    bit         acc;
    int         lvl;
    bit         ovf;
  } vec_t;
  vec_t tbl[20];

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  function automatic int exp_writes(input int d);
    return d + (SYNC ? (d + FL - 1) / FL : 0);
  endfunction

  // UART model and output scoreboard, sampled on the falling edge.
  task automatic uart_mon();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete(); seen.delete();
        m_cnt = 0; m_sync = 1'b0; m_frames = 0; fd_cnt = 0; fd_prev = 1'b0;
      end else begin
        if (Tx_WR) begin
          check("wr_while_busy", int'(Tx_BUSY), 0);
          wr_total++;
          seen.push_back(Tx_DATA);
          if (SYNC && m_cnt == 0 && !m_sync) begin
            m_sync = 1'b1;
            check("tx_sync_byte", int'(Tx_DATA), int'(SYNC_BYTE));
          end else begin
            check("wr_has_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              check("tx_data_order", int'(Tx_DATA), int'(e));
            end
            m_cnt++;
            if (m_cnt == FL) begin m_cnt = 0; m_sync = 1'b0; m_frames++; end
          end
        end
        if (frame_done) begin
          fd_cnt++;
          check("frame_done_order", fd_cnt, m_frames);
          check("frame_done_width", int'(fd_prev), 0);
        end
        fd_prev = frame_done;
      end
      if (!reset && Tx_WR) begin
        busy = 1'b1; busy_cnt = BUSY_LEN;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) busy = 1'b0;
      end
    end
  endtask

  task automatic push(input logic [7:0] b, input bit acc);
    in_valid = 1'b1; in_byte = b;
    if (acc) exp_q.push_back(b);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; hold = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || Tx_BUSY || fifo_level != 0) && t < 3000) begin
      @(negedge clk); t++;
    end
    repeat (5) @(negedge clk);
    check(name, int'(t < 3000), 1);
  endtask

  initial begin
    int n0, peak;
    logic [7:0] sync_exp[$];
    fork uart_mon(); join_none

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx_data", int'(Tx_DATA), 0);
    check("rst_tx_wr", int'(Tx_WR), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_level", int'(fifo_level), 0);
    reset = 1'b0;

    // Single byte latency
    repeat (9) @(negedge clk);
    n0 = wr_total;
    push(8'hA5, 1'b1);
    check("lat_no_wr_n1", int'(Tx_WR), 0);
    @(negedge clk);
    check("lat_wr_n2", int'(Tx_WR), 1);
    check("lat_data_n2", int'(Tx_DATA), SYNC ? int'(SYNC_BYTE) : 'hA5);
    repeat (40) @(negedge clk);
    check("single_level", int'(fifo_level), 0);
    check("single_wr_count", wr_total - n0, exp_writes(1));

    // Burst of 5
    do_reset();
    peak = 0;
    for (int i = 1; i <= 5; i++) begin
      push(8'(i), 1'b1);
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
    end
    check("burst_peak", peak, SYNC ? 5 : 4);
    drain("burst_drain");
    check("burst_writes", seen.size(), exp_writes(5));

    // Overflow, table driven
    for (int i = 0; i < 20; i++) begin
      tbl[i].b   = 8'(i);
      tbl[i].acc = (i < DEPTH);
      tbl[i].lvl = (i < DEPTH) ? i + 1 : DEPTH;
      tbl[i].ovf = (i >= DEPTH);
    end
    do_reset();
    hold = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      push(tbl[i].b, tbl[i].acc);
      check($sformatf("ovf_level_%0d", i), int'(fifo_level), tbl[i].lvl);
      check($sformatf("ovf_flag_%0d", i), int'(overflow), int'(tbl[i].ovf));
    end
    hold = 1'b0;
    drain("ovf_drain");
    check("ovf_writes", seen.size(), exp_writes(DEPTH));
    check("ovf_sticky", int'(overflow), 1);

    // Frame counting
    do_reset();
    for (int i = 0; i < 8; i++) push(8'h20 + 8'(i), 1'b1);
    drain("frame_drain");
    check("frame_count", fd_cnt, 8 / FL);
    check("frame_writes", seen.size(), exp_writes(8));

    // Reset in WAIT_DONE with bytes queued
    do_reset();
    for (int i = 0; i < 4; i++) push(8'h30 + 8'(i), 1'b1);
    repeat (8) @(negedge clk);
    check("mid_level", int'(fifo_level), SYNC ? 4 : 3);
    n0 = wr_total;
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_wr", int'(Tx_WR), 0);
    check("mid_rst_data", int'(Tx_DATA), 0);
    check("mid_rst_fd", int'(frame_done), 0);
    check("mid_rst_level", int'(fifo_level), 0);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    check("mid_no_wr", wr_total - n0, 0);

    // Sync / short stream sequence
    do_reset();
    push(8'h10, 1'b1); push(8'h11, 1'b1); push(8'h12, 1'b1);
    drain("seq_drain");
    if (SYNC) sync_exp = '{8'h47, 8'h10, 8'h11, 8'h47, 8'h12};
    else      sync_exp = '{8'h10, 8'h11, 8'h12};
    check("seq_len", seen.size(), sync_exp.size());
    for (int i = 0; i < sync_exp.size() && i < seen.size(); i++)
      check($sformatf("seq_byte_%0d", i), int'(seen[i]), int'(sync_exp[i]));
    check("seq_frames", fd_cnt, SYNC ? 1 : 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
